// File: rtl/pio_avalon_master.sv
// pio_avalon_master
//
// Avalon-MM master for a PIO-style slave. It issues one transaction at a
// time. A transaction is either a host command from fabric logic or an
// autonomous poll read of word address 0. The poll is requested every
// POLL_PERIOD cycles while poll_enable is high. Host reads return data on
// rsp_readdata with a one-cycle rsp_valid pulse. Poll reads update
// poll_value and pulse change_pulse when the polled value differs from the
// previous one.
//
// Ports:
//   clk, reset        - clock and synchronous active-high reset
//   cmd_*             - host command channel (valid/ready handshake)
//   rsp_valid         - one-cycle pulse for host read data
//   rsp_readdata      - last host read result
//   poll_enable       - runs the poll timer
//   poll_value        - last polled value of address 0
//   change_pulse      - one-cycle pulse when a poll sees a new value
//   avm_*             - Avalon-MM master port
module pio_avalon_master #(
    parameter int ADDR_W       = 2,
    parameter int DATA_W       = 32,
    parameter int READ_LATENCY = 1,
    parameter int POLL_PERIOD  = 50000
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_write,
    input  logic [ADDR_W-1:0] cmd_address,
    input  logic [DATA_W-1:0] cmd_writedata,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_readdata,
    input  logic              poll_enable,
    output logic [DATA_W-1:0] poll_value,
    output logic              change_pulse,
    output logic [ADDR_W-1:0] avm_address,
    output logic              avm_chipselect,
    output logic              avm_read,
    output logic              avm_write,
    output logic [DATA_W-1:0] avm_writedata,
    input  logic [DATA_W-1:0] avm_readdata,
    input  logic              avm_waitrequest
);

    localparam int PCW = (POLL_PERIOD > 2) ? $clog2(POLL_PERIOD) : 1;
    localparam logic [PCW-1:0] POLL_LAST = PCW'(POLL_PERIOD - 1);
    localparam logic [2:0]     LAT_LOAD  = 3'(READ_LATENCY - 1);

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        WAIT_DATA,
        DONE
    } state_t;

    state_t         state;
    logic [PCW-1:0] poll_count;
    logic           poll_pending;
    logic [2:0]     lat_count;
    logic           is_poll;
    logic           poll_tick;
    logic           poll_latch;

    assign cmd_ready      = (state == IDLE);
    assign avm_chipselect = avm_read | avm_write;

    // A host command always wins the IDLE slot, so the poll is taken only
    // when no command is offered in that cycle.
    assign poll_latch = (state == IDLE) && !cmd_valid && poll_pending;
    assign poll_tick  = poll_enable && (poll_count == POLL_LAST);

    // The poll timer runs only while enabled. A tick that arrives while a
    // poll is still pending is absorbed, so ticks never queue up.
    always_ff @(posedge clk) begin
        if (reset) begin
            poll_count   <= '0;
            poll_pending <= 1'b0;
        end else begin
            if (!poll_enable || poll_tick) begin
                poll_count <= '0;
            end else begin
                poll_count <= poll_count + 1'b1;
            end

            if (poll_latch) begin
                poll_pending <= 1'b0;
            end else if (poll_tick) begin
                poll_pending <= 1'b1;
            end
        end
    end

    // Transaction FSM. The strobes are held steady in REQ until the slave
    // drops waitrequest. Read data is sampled READ_LATENCY edges after the
    // edge that accepted the read.
    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= IDLE;
            avm_read      <= 1'b0;
            avm_write     <= 1'b0;
            avm_address   <= '0;
            avm_writedata <= '0;
            lat_count     <= '0;
            is_poll       <= 1'b0;
            rsp_valid     <= 1'b0;
            rsp_readdata  <= '0;
            poll_value    <= '0;
            change_pulse  <= 1'b0;
        end else begin
            rsp_valid    <= 1'b0;
            change_pulse <= 1'b0;

            case (state)
                IDLE: begin
                    if (cmd_valid) begin
                        avm_read      <= !cmd_write;
                        avm_write     <= cmd_write;
                        avm_address   <= cmd_address;
                        avm_writedata <= cmd_writedata;
                        is_poll       <= 1'b0;
                        state         <= REQ;
                    end else if (poll_pending) begin
                        avm_read    <= 1'b1;
                        avm_write   <= 1'b0;
                        avm_address <= '0;
                        is_poll     <= 1'b1;
                        state       <= REQ;
                    end
                end

                REQ: begin
                    if (!avm_waitrequest) begin
                        avm_read  <= 1'b0;
                        avm_write <= 1'b0;
                        if (avm_write) begin
                            state <= IDLE;
                        end else begin
                            lat_count <= LAT_LOAD;
                            state     <= WAIT_DATA;
                        end
                    end
                end

                WAIT_DATA: begin
                    if (lat_count == 3'd0) begin
                        if (is_poll) begin
                            poll_value   <= avm_readdata;
                            change_pulse <= (avm_readdata != poll_value);
                        end else begin
                            rsp_readdata <= avm_readdata;
                            rsp_valid    <= 1'b1;
                        end
                        state <= DONE;
                    end else begin
                        lat_count <= lat_count - 3'd1;
                    end
                end

                DONE: begin
                    state <= IDLE;
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pio_avalon_master.sv
// tb_pio_avalon_master
//
// Drives two instances of pio_avalon_master from shared stimulus. One
// instance uses READ_LATENCY = 1 and the other READ_LATENCY = 3. Both use
// POLL_PERIOD = 8. Each lane has a reference model that tracks transactions
// by edge timestamps: when a command is accepted, when the slave accepts
// it, and when data is due. Every cycle, all outputs of both instances are
// compared with the model.
module tb_pio_avalon_master;

    localparam int PP = 8;

    typedef struct packed {
        logic        cmd_ready;
        logic        avm_read;
        logic        avm_write;
        logic        avm_chipselect;
        logic        rsp_valid;
        logic        change_pulse;
        logic [1:0]  avm_address;
        logic [31:0] avm_writedata;
        logic [31:0] rsp_readdata;
        logic [31:0] poll_value;
        logic        check_addr;
        logic        check_wdata;
    } obs_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        cmd_valid;
    logic        cmd_write;
    logic [1:0]  cmd_address;
    logic [31:0] cmd_writedata;
    logic        poll_enable;
    logic        avm_waitrequest;
    logic [31:0] avm_readdata;

    int tests_run    = 0;
    int tests_failed = 0;

    obs_t act_arr [2];
    obs_t exp_arr [2];

    always #5 clk = ~clk;

    for (genvar g = 0; g < 2; g++) begin : lane
        localparam int RL = (g == 0) ? 1 : 3;

        logic        cmd_ready, rsp_valid, change_pulse;
        logic        avm_chipselect, avm_read, avm_write;
        logic [1:0]  avm_address;
        logic [31:0] rsp_readdata, poll_value, avm_writedata;

        pio_avalon_master #(
            .ADDR_W(2),
            .DATA_W(32),
            .READ_LATENCY(RL),
            .POLL_PERIOD(PP)
        ) dut (
            .clk(clk),
            .reset(reset),
            .cmd_valid(cmd_valid),
            .cmd_ready(cmd_ready),
            .cmd_write(cmd_write),
            .cmd_address(cmd_address),
            .cmd_writedata(cmd_writedata),
            .rsp_valid(rsp_valid),
            .rsp_readdata(rsp_readdata),
            .poll_enable(poll_enable),
            .poll_value(poll_value),
            .change_pulse(change_pulse),
            .avm_address(avm_address),
            .avm_chipselect(avm_chipselect),
            .avm_read(avm_read),
            .avm_write(avm_write),
            .avm_writedata(avm_writedata),
            .avm_readdata(avm_readdata),
            .avm_waitrequest(avm_waitrequest)
        );

        assign act_arr[g] = '{cmd_ready: cmd_ready, avm_read: avm_read,
                              avm_write: avm_write, avm_chipselect: avm_chipselect,
                              rsp_valid: rsp_valid, change_pulse: change_pulse,
                              avm_address: avm_address, avm_writedata: avm_writedata,
                              rsp_readdata: rsp_readdata, poll_value: poll_value,
                              check_addr: 1'b0, check_wdata: 1'b0};

        // Transaction model. n counts edges. While a transaction is open,
        // the model holds its kind, whether the slave has accepted it, and
        // the edge on which read data is due. free_at is the first edge on
        // which a new transaction may be accepted.
        int          n = 0;
        int          cnt = 0;
        int          sample_at = 0;
        int          free_at = 0;
        bit          pending, active, acked, is_write, is_poll, saw_reset;
        logic [1:0]  m_addr = '0;
        logic [31:0] m_wdata = '0;
        logic [31:0] rd_exp = '0;
        logic [31:0] poll_exp = '0;
        bit          rsp_exp, change_exp;
        obs_t        exp_l = '0;

        assign exp_arr[g] = exp_l;

        always @(posedge clk) begin
            bit tick;
            bit took_poll;
            tick      = poll_enable && (cnt == PP - 1);
            took_poll = 1'b0;
            saw_reset = reset;
            if (reset) begin
                cnt        = 0;
                pending    = 1'b0;
                active     = 1'b0;
                free_at    = 0;
                rsp_exp    = 1'b0;
                change_exp = 1'b0;
                rd_exp     = '0;
                poll_exp   = '0;
                m_addr     = '0;
                m_wdata    = '0;
            end else begin
                rsp_exp    = 1'b0;
                change_exp = 1'b0;
                cnt = poll_enable ? (cnt + 1) % PP : 0;
                if (active) begin
                    if (!acked) begin
                        if (!avm_waitrequest) begin
                            acked = 1'b1;
                            if (is_write) begin
                                active  = 1'b0;
                                free_at = n + 1;
                            end else begin
                                sample_at = n + RL;
                            end
                        end
                    end else if (n == sample_at) begin
                        if (is_poll) begin
                            change_exp = (avm_readdata != poll_exp);
                            poll_exp   = avm_readdata;
                        end else begin
                            rd_exp  = avm_readdata;
                            rsp_exp = 1'b1;
                        end
                        active  = 1'b0;
                        free_at = n + 2;
                    end
                end else if (n >= free_at) begin
                    if (cmd_valid) begin
                        active   = 1'b1;
                        acked    = 1'b0;
                        is_write = cmd_write;
                        is_poll  = 1'b0;
                        m_addr   = cmd_address;
                        m_wdata  = cmd_writedata;
                    end else if (pending) begin
                        active    = 1'b1;
                        acked     = 1'b0;
                        is_write  = 1'b0;
                        is_poll   = 1'b1;
                        m_addr    = '0;
                        took_poll = 1'b1;
                    end
                end
                if (took_poll) begin
                    pending = 1'b0;
                end else if (tick) begin
                    pending = 1'b1;
                end
            end
            n = n + 1;

            exp_l.cmd_ready      = !active && (n >= free_at);
            exp_l.avm_read       = active && !acked && !is_write;
            exp_l.avm_write      = active && !acked && is_write;
            exp_l.avm_chipselect = active && !acked;
            exp_l.rsp_valid      = rsp_exp;
            exp_l.change_pulse   = change_exp;
            exp_l.avm_address    = m_addr;
            exp_l.avm_writedata  = m_wdata;
            exp_l.rsp_readdata   = rd_exp;
            exp_l.poll_value     = poll_exp;
            exp_l.check_addr     = saw_reset || (active && !acked);
            exp_l.check_wdata    = saw_reset || (active && !acked && is_write);
        end
    end

    task automatic checkOutput(input string tag, input logic [31:0] actual,
                               input logic [31:0] expected);
        tests_run++;
        if (actual !== expected) begin
            tests_failed++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, actual, expected);
        end
    endtask

    // Compare both lanes one time unit after every rising edge.
    always @(posedge clk) begin
        #1;
        for (int i = 0; i < 2; i++) begin
            checkOutput($sformatf("L%0d cmd_ready", i), 32'(act_arr[i].cmd_ready), 32'(exp_arr[i].cmd_ready));
            checkOutput($sformatf("L%0d avm_read", i), 32'(act_arr[i].avm_read), 32'(exp_arr[i].avm_read));
            checkOutput($sformatf("L%0d avm_write", i), 32'(act_arr[i].avm_write), 32'(exp_arr[i].avm_write));
            checkOutput($sformatf("L%0d avm_chipselect", i), 32'(act_arr[i].avm_chipselect), 32'(exp_arr[i].avm_chipselect));
            checkOutput($sformatf("L%0d rsp_valid", i), 32'(act_arr[i].rsp_valid), 32'(exp_arr[i].rsp_valid));
            checkOutput($sformatf("L%0d change_pulse", i), 32'(act_arr[i].change_pulse), 32'(exp_arr[i].change_pulse));
            checkOutput($sformatf("L%0d rsp_readdata", i), act_arr[i].rsp_readdata, exp_arr[i].rsp_readdata);
            checkOutput($sformatf("L%0d poll_value", i), act_arr[i].poll_value, exp_arr[i].poll_value);
            if (exp_arr[i].check_addr) begin
                checkOutput($sformatf("L%0d avm_address", i), 32'(act_arr[i].avm_address), 32'(exp_arr[i].avm_address));
            end
            if (exp_arr[i].check_wdata) begin
                checkOutput($sformatf("L%0d avm_writedata", i), act_arr[i].avm_writedata, exp_arr[i].avm_writedata);
            end
        end
    end

    // One cycle of stimulus, applied on the falling edge.
    task automatic applyStimulus(input bit valid, input bit write, input logic [1:0] addr,
                                 input logic [31:0] wdata, input bit stall,
                                 input logic [31:0] rdata);
        @(negedge clk);
        cmd_valid       = valid;
        cmd_write       = write;
        cmd_address     = addr;
        cmd_writedata   = wdata;
        avm_waitrequest = stall;
        avm_readdata    = rdata;
    endtask

    initial begin
        logic [31:0] steps [4];
        steps = '{32'h0, 32'h5, 32'h5, 32'h7};

        reset           = 1'b1;
        cmd_valid       = 1'b0;
        cmd_write       = 1'b0;
        cmd_address     = '0;
        cmd_writedata   = '0;
        poll_enable     = 1'b0;
        avm_waitrequest = 1'b0;
        avm_readdata    = '0;
        repeat (3) @(negedge clk);
        reset = 1'b0;

        // Host write with three wait states.
        applyStimulus(1'b1, 1'b1, 2'd0, 32'h0000_A5A5, 1'b1, 32'h0);
        repeat (3) applyStimulus(1'b0, 1'b0, 2'd0, 32'h0, 1'b1, 32'h0);
        repeat (4) applyStimulus(1'b0, 1'b0, 2'd0, 32'h0, 1'b0, 32'h0);

        // Host read returning 0x1234.
        applyStimulus(1'b1, 1'b0, 2'd0, 32'h0, 1'b0, 32'h0000_1234);
        repeat (8) applyStimulus(1'b0, 1'b0, 2'd0, 32'h0, 1'b0, 32'h0000_1234);

        // Poll sequence with the slave value stepping 0, 5, 5, 7.
        poll_enable = 1'b1;
        for (int s = 0; s < 4; s++) begin
            repeat (12) applyStimulus(1'b0, 1'b0, 2'd0, 32'h0, 1'b0, steps[s]);
        end

        // Random traffic with polling, collisions, stalls and changing readdata.
        for (int i = 0; i < 1500; i++) begin
            applyStimulus($urandom_range(0, 2) == 0, $urandom_range(0, 1) == 1,
                          2'($urandom_range(0, 3)), $urandom,
                          $urandom_range(0, 3) == 0, 32'($urandom_range(0, 3)));
            reset = ($urandom_range(0, 199) == 0);
            if ($urandom_range(0, 49) == 0) poll_enable = !poll_enable;
        end
        reset = 1'b0;

        // Reset pulse while the latency-3 lane waits for read data.
        poll_enable = 1'b0;
        repeat (14) applyStimulus(1'b0, 1'b0, 2'd0, 32'h0, 1'b0, 32'h0);
        applyStimulus(1'b1, 1'b0, 2'd1, 32'h0, 1'b0, 32'hDEAD_0001);
        applyStimulus(1'b0, 1'b0, 2'd0, 32'h0, 1'b0, 32'hDEAD_0002);
        applyStimulus(1'b0, 1'b0, 2'd0, 32'h0, 1'b0, 32'hDEAD_0003);
        reset = 1'b1;
        applyStimulus(1'b0, 1'b0, 2'd0, 32'h0, 1'b0, 32'hDEAD_0004);
        reset = 1'b0;
        poll_enable = 1'b1;
        repeat (30) applyStimulus(1'b0, 1'b0, 2'd0, 32'h0, 1'b0, 32'h0000_0009);

        repeat (2) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
